// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch (IF) and data (DM) requesters
// One transaction in flight at a time, DM-priority with an IF anti-starvation burst cap and a bus watchdog.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_DBURST = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ready,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_wstrb,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_ready,
  output logic            mem_valid,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall_f,
  output logic            stall_m,
  output logic            err
);

  localparam int SW = DW / 8;
  localparam int BW = (MAX_DBURST < 1) ? 1 : $clog2(MAX_DBURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DBURST);
  localparam logic [7:0]    TMO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ERR} state_t;

  state_t          state_q, state_d;
  logic            mem_valid_q, mem_valid_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic            if_ready_q, if_ready_d;
  logic            dm_ready_q, dm_ready_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
  logic            err_q, err_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [7:0]      tmo_cnt_q, tmo_cnt_d;

  logic if_ok, dm_ok, grant_i, grant_d;

  // A requester completing this cycle still holds its old req; mask it.
  assign if_ok = if_req & ~if_ready_q;
  assign dm_ok = dm_req & ~dm_ready_q;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;
    tmo_cnt_d   = tmo_cnt_q;
    burst_cnt_d = burst_cnt_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    case (state_q)
      IDLE: begin
        grant_i = if_ok & (~dm_ok | (burst_cnt_q == BURST_MAX));
        grant_d = dm_ok & ~grant_i;
        if (grant_i) begin
          state_d     = BUSY_I;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          tmo_cnt_d   = '0;
        end else if (grant_d) begin
          state_d     = BUSY_D;
          mem_valid_d = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wstrb_d = dm_we ? dm_wstrb : '0;
          tmo_cnt_d   = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = IDLE;
          if (state_q == BUSY_I) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            dm_rdata_d = mem_we_q ? '0 : mem_rdata;
            dm_ready_d = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (tmo_cnt_q == TMO_LAST) begin
            state_d     = ERR;
            mem_valid_d = 1'b0;
            err_d       = 1'b1;
          end
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    if (!if_req || grant_i) begin
      burst_cnt_d = '0;
    end else if (grant_d && (burst_cnt_q != BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
      burst_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
      burst_cnt_q <= burst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign stall_f   = if_req & ~if_ready_q;
  assign stall_m   = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Transaction-level reference model plus directed literal checks and random traffic.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXB = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [SW-1:0] dm_wstrb = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall_f;
  logic          stall_m;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DBURST(MAXB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m), .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // phase: 0 = nothing outstanding, 1 = transaction on the bus, 2 = dead after timeout
  typedef struct {
    int          phase;
    bit          owner_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waited;
    bit          if_rdy;
    bit          dm_rdy;
    logic [31:0] if_rd;
    logic [31:0] dm_rd;
    int          burst;
    bit          err;
  } model_t;

  model_t m, mn;

  function automatic model_t model_reset();
    model_t r;
    r.phase = 0; r.owner_dm = 0; r.we = 0; r.addr = 0; r.wdata = 0; r.wstrb = 0;
    r.waited = 0; r.if_rdy = 0; r.dm_rdy = 0; r.if_rd = 0; r.dm_rd = 0;
    r.burst = 0; r.err = 0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t s);
    model_t n;
    bit want_if, want_dm, take_if, take_dm;
    n = s;
    n.if_rdy = 0;
    n.dm_rdy = 0;
    take_if = 0;
    take_dm = 0;
    if (!rst_n) return model_reset();
    if (s.phase == 0) begin
      want_if = if_req && !s.if_rdy;
      want_dm = dm_req && !s.dm_rdy;
      if (want_if && (!want_dm || s.burst == MAXB)) take_if = 1;
      else if (want_dm) take_dm = 1;
      if (take_if) begin
        n.phase = 1; n.owner_dm = 0; n.we = 0; n.addr = if_addr; n.wstrb = 0; n.waited = 0;
      end
      if (take_dm) begin
        n.phase = 1; n.owner_dm = 1; n.we = dm_we; n.addr = dm_addr; n.wdata = dm_wdata;
        n.wstrb = dm_we ? dm_wstrb : 4'h0; n.waited = 0;
      end
    end else if (s.phase == 1) begin
      if (mem_ready) begin
        n.phase = 0;
        if (s.owner_dm) begin n.dm_rdy = 1; n.dm_rd = s.we ? 32'h0 : mem_rdata; end
        else begin n.if_rdy = 1; n.if_rd = mem_rdata; end
      end else begin
        n.waited = s.waited + 1;
        if (n.waited >= TMO) begin n.phase = 2; n.err = 1; end
      end
    end
    if (!if_req || take_if) n.burst = 0;
    else if (take_dm) n.burst = (s.burst + 1 > MAXB) ? MAXB : s.burst + 1;
    return n;
  endfunction

  task automatic compare_model();
    chk("m_mem_valid", mem_valid, m.phase == 1);
    if (m.phase == 1) begin
      chk("m_mem_we", mem_we, m.we);
      chk("m_mem_addr", mem_addr, m.addr);
      chk("m_mem_wstrb", mem_wstrb, m.wstrb);
      if (m.we) chk("m_mem_wdata", mem_wdata, m.wdata);
    end
    chk("m_if_ready", if_ready, m.if_rdy);
    chk("m_dm_ready", dm_ready, m.dm_rdy);
    if (m.if_rdy) chk("m_if_rdata", if_rdata, m.if_rd);
    if (m.dm_rdy) chk("m_dm_rdata", dm_rdata, m.dm_rd);
    chk("m_err", err, m.err);
    chk("m_stall_f", stall_f, if_req && !m.if_rdy);
    chk("m_stall_m", stall_m, dm_req && !m.dm_rdy);
  endtask

  // Called just after a rising edge with inputs already driven; returns just after the next one.
  task automatic tick();
    #1;
    compare_model();
    mn = model_next(m);
    @(posedge clk);
    #1;
    m = mn;
  endtask

  task automatic clear_inputs();
    if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    m = model_reset();
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    m = model_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_dm_ready", dm_ready, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_err", err, 0);

    // zero-wait fetch
    if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("t1_c1_valid", mem_valid, 1);
    chk("t1_c1_addr", mem_addr, 32'h100);
    chk("t1_c1_wstrb", mem_wstrb, 0);
    chk("t1_c1_ready", if_ready, 0);
    tick();
    chk("t1_c2_ready", if_ready, 1);
    chk("t1_c2_rdata", if_rdata, 32'hDEADBEEF);
    tick();
    chk("t1_c3_noregrant", mem_valid, 0);
    chk("t1_c3_ready", if_ready, 0);
    if_req = 0;
    tick();

    // simultaneous IF and DM load
    if_req = 1; if_addr = 32'h300; dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    mem_ready = 1; mem_rdata = 32'hCAFE0001;
    tick();
    chk("t2_c1_addr", mem_addr, 32'h2000);
    chk("t2_c1_stall_f", stall_f, 1);
    tick();
    chk("t2_c2_dm_ready", dm_ready, 1);
    chk("t2_c2_dm_rdata", dm_rdata, 32'hCAFE0001);
    chk("t2_c2_stall_f", stall_f, 1);
    dm_req = 0; mem_rdata = 32'hF00D0002;
    tick();
    chk("t2_c3_addr", mem_addr, 32'h300);
    chk("t2_c3_valid", mem_valid, 1);
    chk("t2_c3_stall_f", stall_f, 1);
    tick();
    chk("t2_c4_if_ready", if_ready, 1);
    chk("t2_c4_if_rdata", if_rdata, 32'hF00D0002);
    if_req = 0;
    tick();

    // store with three wait cycles, then a load with strobes set
    dm_req = 1; dm_we = 1; dm_addr = 32'h44; dm_wdata = 32'h12345678; dm_wstrb = 4'b0011;
    mem_ready = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("t4_valid", mem_valid, 1);
      chk("t4_we", mem_we, 1);
      chk("t4_addr", mem_addr, 32'h44);
      chk("t4_wdata", mem_wdata, 32'h12345678);
      chk("t4_wstrb", mem_wstrb, 4'b0011);
      chk("t4_no_ready", dm_ready, 0);
      if (c == 4) mem_ready = 1;
    end
    tick();
    chk("t4_c5_dm_ready", dm_ready, 1);
    chk("t4_c5_store_rdata", dm_rdata, 0);
    dm_req = 0;
    tick();
    dm_req = 1; dm_we = 0; dm_addr = 32'h48; dm_wstrb = 4'hF;
    tick();
    chk("t4_load_wstrb", mem_wstrb, 0);
    chk("t4_load_we", mem_we, 0);
    tick();
    dm_req = 0;
    tick();

    // watchdog
    if_req = 1; if_addr = 32'h500; mem_ready = 0;
    for (int c = 1; c <= TMO; c++) begin
      tick();
      chk("t5_busy_valid", mem_valid, 1);
      chk("t5_busy_err", err, 0);
    end
    tick();
    chk("t5_err", err, 1);
    chk("t5_valid_dropped", mem_valid, 0);
    dm_req = 1; dm_we = 0; mem_ready = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_stall_f", stall_f, 1);
      chk("t5_stall_m", stall_m, 1);
      chk("t5_no_grant", mem_valid, 0);
    end
    do_reset();
    chk("t5_err_cleared", err, 0);

    // async reset in the middle of a DM transaction
    dm_req = 1; dm_we = 0; dm_addr = 32'h7000; mem_ready = 0;
    tick();
    chk("t6_busy", mem_valid, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t6_async_drop", mem_valid, 0);
    m = model_reset();
    tick();
    rst_n = 1;
    tick();
    chk("t6_regrant", mem_valid, 1);
    chk("t6_regrant_addr", mem_addr, 32'h7000);
    mem_ready = 1;
    tick();
    chk("t6_done", dm_ready, 1);
    dm_req = 0;
    tick();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (m.err) do_reset();
      if (!if_req || if_ready) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
      end
      if (!dm_req || dm_ready) begin
        dm_req = ($urandom_range(0, 2) != 0);
        dm_we = $urandom_range(0, 1);
        dm_addr = $urandom;
        dm_wdata = $urandom;
        dm_wstrb = 4'($urandom);
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
